// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read, single-port data memory between two
//   requesters: port 0 (core data load/store traffic) and port 1 (program
//   loader / debug access). Arbitration is round-robin. A port may ask to
//   keep the grant (lock) so that multi-beat loader bursts stay contiguous.
//   While the other port is waiting, a lock is honoured for at most
//   MAX_LOCK consecutive grants.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   req0/1, we0/1         access request and write enable per port
//   lock0/1               ask to keep the grant on the next cycle
//   addr0/1, wdata0/1     byte address and write data per port
//   gnt0/1                access accepted this cycle (combinational)
//   rvalid0/1, rdata0/1   read return, one cycle after a granted read
//   mem_en/we/addr/wdata  memory strobe and muxed request fields
//   mem_rdata             memory read data, valid the cycle after a read
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK);

  // State records which port was granted last cycle (or none).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            last_gnt_reg, last_gnt_next;
  logic            lock_hold_reg, lock_hold_next;   // lock bit of last grant
  logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic            rd_pend_reg, rd_pend_next;
  logic            rd_port_reg, rd_port_next;

  logic            g0, g1;
  logic            lock_force0, lock_force1;
  logic            held_same;     // grant stays with last cycle's holder
  logic            grant_lock;    // lock request of the port granted now
  logic            other_req;     // the non-granted port is waiting
  logic [CW-1:0]   cnt_base;

  // ------------------------------------------------------------------
  // Grant selection and next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    g0             = 1'b0;
    g1             = 1'b0;
    lock_force0    = 1'b0;
    lock_force1    = 1'b0;
    held_same      = 1'b0;
    grant_lock     = 1'b0;
    other_req      = 1'b0;
    cnt_base       = '0;
    state_next     = ST_IDLE;
    last_gnt_next  = last_gnt_reg;
    lock_hold_next = 1'b0;
    lock_cnt_next  = '0;
    rd_pend_next   = 1'b0;
    rd_port_next   = rd_port_reg;

    if (!reset) begin
      // A lock only binds when the holder granted last cycle asked for it
      // and is still requesting.
      lock_force0 = (state_reg == ST_OWN0) && lock_hold_reg && req0;
      lock_force1 = (state_reg == ST_OWN1) && lock_hold_reg && req1;

      if (lock_force0) begin
        if (req1 && (lock_cnt_reg >= LOCK_LIMIT)) g1 = 1'b1;
        else                                      g0 = 1'b1;
      end else if (lock_force1) begin
        if (req0 && (lock_cnt_reg >= LOCK_LIMIT)) g0 = 1'b1;
        else                                      g1 = 1'b1;
      end else if (req0 && req1) begin
        // Tie: the port that was not served most recently wins.
        if (last_gnt_reg) g0 = 1'b1;
        else              g1 = 1'b1;
      end else if (req0) begin
        g0 = 1'b1;
      end else if (req1) begin
        g1 = 1'b1;
      end
    end

    // FSM and priority bookkeeping
    if (g0) begin
      state_next     = ST_OWN0;
      last_gnt_next  = 1'b0;
      lock_hold_next = lock0;
    end else if (g1) begin
      state_next     = ST_OWN1;
      last_gnt_next  = 1'b1;
      lock_hold_next = lock1;
    end

    // Lock counter: counts locked grants made while the other port waits,
    // including the first grant of a run, so MAX_LOCK is the number of
    // contended grants the holder receives before being preempted.
    held_same  = (g0 && (state_reg == ST_OWN0)) || (g1 && (state_reg == ST_OWN1));
    grant_lock = g0 ? lock0 : lock1;
    other_req  = g0 ? req1  : req0;
    cnt_base   = held_same ? lock_cnt_reg : '0;
    if ((g0 || g1) && grant_lock) begin
      if (!other_req)                  lock_cnt_next = cnt_base;
      else if (cnt_base != LOCK_LIMIT) lock_cnt_next = cnt_base + 1'b1;
      else                             lock_cnt_next = cnt_base;
    end

    // Read tracking: a granted read returns exactly one cycle later.
    if (g0 && !we0) begin
      rd_pend_next = 1'b1;
      rd_port_next = 1'b0;
    end else if (g1 && !we1) begin
      rd_pend_next = 1'b1;
      rd_port_next = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      last_gnt_reg  <= 1'b1;   // port 0 wins the first tie
      lock_hold_reg <= 1'b0;
      lock_cnt_reg  <= '0;
      rd_pend_reg   <= 1'b0;   // any in-flight read is dropped
      rd_port_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_gnt_reg  <= last_gnt_next;
      lock_hold_reg <= lock_hold_next;
      lock_cnt_reg  <= lock_cnt_next;
      rd_pend_reg   <= rd_pend_next;
      rd_port_reg   <= rd_port_next;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign gnt0      = g0;
  assign gnt1      = g1;
  assign mem_en    = g0 | g1;
  assign mem_we    = g0 ? we0    : (g1 ? we1    : 1'b0);
  assign mem_addr  = g0 ? addr0  : (g1 ? addr1  : '0);
  assign mem_wdata = g0 ? wdata0 : (g1 ? wdata1 : '0);

  // The pending flag is gated by reset so a read granted in the cycle
  // before reset asserts never shows up as a return.
  assign rvalid0 = rd_pend_reg && !rd_port_reg && !reset;
  assign rvalid1 = rd_pend_reg &&  rd_port_reg && !reset;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_LOCK = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory; contents are set to a known pattern in reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // Scoreboard: expected read returns are queued on the grant cycle and
  // compared against the rvalid/rdata seen one cycle later.
  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
          errors++;
          $display("FAIL sb_reset_rvalid: rvalid0=%b rvalid1=%b required 0/0", rvalid0, rvalid1);
        end
        sbq.delete();
      end else begin
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_rvalid: rvalid0=%b rvalid1=%b required none", rvalid0, rvalid1);
          end else begin
            e = sbq.pop_front();
            if (rvalid0 !== !e.port || rvalid1 !== e.port ||
                (e.port ? rdata1 : rdata0) !== e.data) begin
              errors++;
              $display("FAIL sb_read_return: rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h required port%0d data %h",
                       rvalid0, rvalid1, rdata0, rdata1, e.port, e.data);
            end else begin
              $display("read return port%0d data %h", e.port, e.data);
            end
          end
        end else if (sbq.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL sb_missing_rvalid: rvalid0=%b rvalid1=%b required port%0d return",
                   rvalid0, rvalid1, sbq[0].port);
          sbq.delete();
        end
        if (gnt0 === 1'b1 && mem_we === 1'b0) sbq.push_back('{1'b0, mem[mem_addr[9:2]]});
        if (gnt1 === 1'b1 && mem_we === 1'b0) sbq.push_back('{1'b1, mem[mem_addr[9:2]]});
      end
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); req0 = 1; req1 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 0 || gnt1 !== 0 || mem_en !== 0 || rvalid0 !== 0 || rvalid1 !== 0) begin
        errors++;
        $display("FAIL reset_outputs: gnt0=%b gnt1=%b mem_en=%b rvalid0=%b rvalid1=%b required all 0",
                 gnt0, gnt1, mem_en, rvalid0, rvalid1);
      end else $display("reset cycle %0d outputs quiet", i);
    end
    next_cycle(); reset = 0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1 || gnt1 !== 0) begin
      errors++;
      $display("FAIL reset_first_tie: gnt0=%b gnt1=%b required 1/0", gnt0, gnt1);
    end else $display("first tie after reset -> port0");
    next_cycle(); idle_inputs();
  endtask

  task automatic test_write();
    req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1 || gnt0 !== 0 || mem_en !== 1 || mem_we !== 1 ||
        mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_mux: gnt1=%b en=%b we=%b addr=%h wdata=%h required 1/1/1/00000010/deadbeef",
               gnt1, mem_en, mem_we, mem_addr, mem_wdata);
    end else $display("write port1 addr 10 data deadbeef");
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++;
    if (rvalid1 !== 0 || rvalid0 !== 0 || mem_en !== 0 || mem_addr !== 0) begin
      errors++;
      $display("FAIL write_no_rvalid: rvalid1=%b rvalid0=%b mem_en=%b mem_addr=%h required 0/0/0/0",
               rvalid1, rvalid0, mem_en, mem_addr);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1 || mem_addr !== 32'h10 || mem_we !== 0 || mem_en !== 1) begin
      errors++;
      $display("FAIL single_read_grant: gnt0=%b addr=%h we=%b en=%b required 1/00000010/0/1",
               gnt0, mem_addr, mem_we, mem_en);
    end else $display("read port0 addr 10 granted");
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 0 || rdata1 !== 0) begin
      errors++;
      $display("FAIL single_read_return: rvalid0=%b rdata0=%h rvalid1=%b rdata1=%h required 1/deadbeef/0/0",
               rvalid0, rdata0, rvalid1, rdata1);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    // One port1 access leaves port1 as the most recent winner.
    req1 = 1; addr1 = 32'h20;
    next_cycle();
    req0 = 1; addr0 = 32'h30; addr1 = 32'h34;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== ((i % 2) == 0) || gnt1 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL round_robin_%0d: gnt0=%b gnt1=%b required port%0d", i, gnt0, gnt1, i % 2);
      end else $display("round robin cycle %0d -> port%0d", i, i % 2);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    req0 = 1;
    for (int i = 0; i < 5; i++) begin
      addr0 = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1 || mem_addr !== addr0 || (i > 0 && rvalid0 !== 1)) begin
        errors++;
        $display("FAIL back_to_back_%0d: gnt0=%b addr=%h rvalid0=%b required 1/%h/%b",
                 i, gnt0, mem_addr, rvalid0, addr0, i > 0);
      end else $display("back-to-back read %0d addr %h", i, addr0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_bounded_lock();
    // Port0 access first so that the following tie goes to port1.
    req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'h1;
    next_cycle();
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h84; wdata1 = 32'h2;
    for (int i = 0; i < MAX_LOCK + 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt1 !== (i != MAX_LOCK) || gnt0 !== (i == MAX_LOCK)) begin
        errors++;
        $display("FAIL bounded_lock_%0d: gnt0=%b gnt1=%b required %b/%b",
                 i, gnt0, gnt1, i == MAX_LOCK, i != MAX_LOCK);
      end else $display("bounded lock cycle %0d -> port%0d", i, gnt1 ? 1 : 0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_unbounded_lock();
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 32'h90;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 1 || gnt1 !== 0) begin
        errors++;
        $display("FAIL unbounded_lock_%0d: gnt0=%b gnt1=%b required 1/0", i, gnt0, gnt1);
      end
      next_cycle();
    end
    $display("unbounded lock held port0 for 20 cycles");
    req1 = 1; we1 = 1; addr1 = 32'h94;
    for (int i = 0; i < MAX_LOCK + 1; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== (i < MAX_LOCK) || gnt1 !== (i == MAX_LOCK)) begin
        errors++;
        $display("FAIL contended_lock_%0d: gnt0=%b gnt1=%b required %b/%b",
                 i, gnt0, gnt1, i < MAX_LOCK, i == MAX_LOCK);
      end else $display("contended lock cycle %0d -> port%0d", i, gnt1 ? 1 : 0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    req1 = 1; addr1 = 32'h44;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1) begin
      errors++;
      $display("FAIL mid_read_grant: gnt1=%b required 1", gnt1);
    end
    next_cycle(); idle_inputs(); reset = 1;
    @(negedge clk);
    checks++;
    if (rvalid1 !== 0 || rdata1 !== 0) begin
      errors++;
      $display("FAIL mid_read_reset: rvalid1=%b rdata1=%h required 0/0", rvalid1, rdata1);
    end else $display("read dropped by reset");
    next_cycle(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid0 !== 0 || rvalid1 !== 0) begin
        errors++;
        $display("FAIL mid_read_stale_%0d: rvalid0=%b rvalid1=%b required 0/0", i, rvalid0, rvalid1);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_write();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_bounded_lock();
    test_unbounded_lock();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous-read, single-port data memory between two requesters.
- Port 0 is the core data port (store/load traffic). Port 1 is the program loader / debug access port.
- Round-robin arbitration with an optional bounded lock, so that multi-beat loader bursts are not interleaved.
- Sits between the processor top level, the loader, and the data memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_LOCK, 8, max consecutive grants to one locked port while the other port is requesting (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  access request, ports 0/1
- we0, we1  in  1  1=write, 0=read
- lock0, lock1  in  1  request to keep the grant on the next cycle
- addr0, addr1  in  AW  byte address
- wdata0, wdata1  in  DW  write data
- gnt0, gnt1  out  1  access accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid (registered)
- rdata0, rdata1  out  DW  read data, valid when rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read strobe

Behaviour:
- **Handshake:** a requester holds req/we/addr/wdata stable until it sees gnt in the same cycle. A transfer completes on the req & gnt cycle.
- **Grant rules:**
  - At most one gnt per cycle; gnt only when the matching req=1.
  - mem_en = gnt0|gnt1. mem_we/addr/wdata are muxed from the granted port.
  - When nothing is granted, mem_* = 0.
- **Priority state:** register last_gnt (0/1).
  - Both requesting, no lock in force: grant the port != last_gnt.
  - Single requester: grant it immediately.
- **Lock:**
  - If the port granted last cycle had lock=1 and still requests, it keeps the grant.
  - Exception: the other port is requesting and lock_cnt has reached MAX_LOCK. Then grant the other port and clear lock_cnt.
  - lock_cnt increments on each consecutive locked grant while the other port is requesting. It clears whenever the grant switches or the holder drops lock.
  - Lock has no effect while the other port is idle (unbounded).
- **Read return:**
  - Register rd_pend (1 bit) and rd_port on a granted read.
  - Next cycle: rvalid<port>=1 and rdata<port>=mem_rdata; the other port's rvalid=0.
  - rdata of a port not being returned holds 0.
  - Writes produce no rvalid.
  - Back-to-back reads are allowed: one read per cycle, return latency exactly 1.
- **FSM:** IDLE (no grant last cycle), OWN0, OWN1 (port granted last cycle). Transitions follow the grant rules; the state equals the last grant or IDLE. last_gnt keeps its value through IDLE.
- **Reset** (synchronous, 1 cycle):
  - state=IDLE, last_gnt=1 (so port 0 wins the first tie), lock_cnt=0, rd_pend=0.
  - Outputs: rvalid0/1=0, rdata0/1=0.
  - gnt/mem_* follow req combinationally but are forced to 0 while reset=1.
  - A read pending at reset is dropped; no rvalid follows.
- **Simultaneous events:**
  - A read return and a new grant in the same cycle are independent.
  - req asserted in the reset-release cycle is arbitrated normally on the next edge-free cycle after reset deasserts.

Test Plan:
1. **Reset:** hold reset 2 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_en=0, rvalid0/1=0. First cycle after release -> gnt0=1.
2. **Single read:** req0=1, we0=0, addr0=0x10, mem_rdata=0xDEADBEEF next cycle -> gnt0=1 cycle N, mem_addr=0x10, mem_we=0; rvalid0=1, rdata0=0xDEADBEEF cycle N+1, rvalid1=0.
3. **Round robin:** req0=req1=1 continuously, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1; exactly one gnt per cycle.
4. **Bounded lock:** req0=req1=1, lock1=1, starting with gnt1 -> port 1 granted MAX_LOCK=8 consecutive cycles, then gnt0=1 for one cycle, then port 1 again.
5. **Unbounded lock:** lock0=1, req1=0 for 20 cycles -> gnt0=1 all 20 cycles. Then req1=1 -> port 0 keeps the grant until 8 contended grants, then gnt1.
6. **Reset mid-read:** granted read on port 1 at cycle N, reset=1 at cycle N+1 -> rvalid1=0 at N+1 and after; no stale return after release.
